// File: rtl/tsp_pkg.sv
// -----------------------------------------------------------------------------
// tsp_pkg
// Shared constants and types for the TensorStreamingProcessor datapath.
//   INSTRUCTION_WIDTH   : width of one ICU instruction word
//   instr_t             : one instruction word
//   NUM_TILES_PER_SLICE : tiles per superlane slice
//   MIN_VEC_LENGTH      : shortest vector the streaming units handle
// -----------------------------------------------------------------------------
package tsp_pkg;

    localparam int INSTRUCTION_WIDTH   = 32;
    localparam int NUM_TILES_PER_SLICE = 20;
    localparam int MIN_VEC_LENGTH      = 16;

    typedef logic [INSTRUCTION_WIDTH-1:0] instr_t;

endpackage : tsp_pkg

// File: rtl/icu_instruction_queue.sv
// -----------------------------------------------------------------------------
// icu_instruction_queue
// First-word-fall-through instruction FIFO sitting in front of the ICU.
// The loader pushes words; the ICU consumes the head on a valid/ready handshake.
//
// Ports
//   clk               : rising-edge clock
//   rst               : synchronous active-low reset
//   flush             : synchronous clear of pointers, count and overflow
//   wr_en / wr_data   : push request and word from the loader
//   full              : count == DEPTH
//   almost_full       : count >= ALMOST_FULL_LEVEL
//   instruction_in    : head word (combinational read of storage)
//   instruction_valid : head word is valid (count != 0)
//   instruction_ready : ICU takes the head word this cycle
//   fifo_empty        : count == 0
//   count             : occupancy 0..DEPTH
//   overflow          : sticky, set when a push is attempted while full
// -----------------------------------------------------------------------------
module icu_instruction_queue
    import tsp_pkg::*;
#(
    parameter int DEPTH             = 16,
    parameter int ALMOST_FULL_LEVEL = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  instr_t                   wr_data,
    output logic                     full,
    output logic                     almost_full,
    output instr_t                   instruction_in,
    output logic                     instruction_valid,
    input  logic                     instruction_ready,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMOST_FULL_LEVEL);

    instr_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               overflow_q, overflow_d;

    logic               push;
    logic               pop;

    // Status is taken from the registered count only, so nothing on the
    // write or ready side reaches these outputs combinationally.
    assign full              = (count_q == FULL_CNT);
    assign almost_full       = (count_q >= AF_CNT);
    assign fifo_empty        = (count_q == '0);
    assign instruction_valid = !fifo_empty;
    assign count             = count_q;
    assign overflow          = overflow_q;
    assign instruction_in    = mem_q[rd_ptr_q];

    // Full blocks pushes even when a pop happens in the same cycle; this keeps
    // instruction_ready out of the push decision.
    assign push = wr_en && !full && !flush;
    assign pop  = instruction_valid && instruction_ready && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (wr_en && full) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset; an entry is only read while it is counted.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule : icu_instruction_queue
